color_matrix_pipe: RTL and testbench
====================================

COLOR_MATRIX_PIPE -- requirements
Module: color_matrix_pipe

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 16: unsigned bits per channel sample.
REQ-002 SHALL have parameter NUM_CH, default 3: channel count; the matrix is NUM_CH x NUM_CH.
REQ-003 SHALL have parameter INT_BITS, default 6: signed integer bits of each coefficient, sign bit included.
REQ-004 SHALL have parameter FRAC_BITS, default 6: fractional bits of each coefficient; legal range >= 1.
REQ-005 SHALL have ports clk (in, 1: sole clock, rising edge) and reset_n (in, 1: reset, asynchronous, active-low), listed first; one clock, and reset is asynchronous and active-low.
REQ-006 SHALL have ports in_valid (in, 1) and in_ready (out, 1): input handshake.
REQ-007 SHALL have port in_pix (in, NUM_CH*PIXEL_WIDTH): input pixel, channel 0 in the LSBs.
REQ-008 SHALL have ports out_valid (out, 1) and out_ready (in, 1): output handshake.
REQ-009 SHALL have port out_pix (out, NUM_CH*PIXEL_WIDTH): converted pixel, channel 0 in the LSBs.
REQ-010 SHALL have ports coeff_we (in, 1), coeff_addr (in, clog2(NUM_CH*NUM_CH+NUM_CH)) and coeff_wdata (in, INT_BITS+FRAC_BITS, signed): shadow-register write port.
REQ-011 SHALL have port coeff_commit (in, 1): one-cycle pulse that requests shadow-to-active copy.
REQ-012 SHALL have ports bypass (in, 1: pass pixels unmodified) and commit_pending (out, 1: commit waiting for drain).

Function
REQ-013 SHALL map addr r*NUM_CH+c to coefficient M[r][c] and addr NUM_CH*NUM_CH+r to offset O[r]; the offset uses only the low PIXEL_WIDTH+1 bits of wdata, signed integer; writes to out-of-range addr are ignored.
REQ-014 SHALL compute out[r] = clip(round(sum over c of in[c]*M[r][c]) + O[r]), with in[c] zero-extended to signed and the accumulator wide enough that no overflow is possible.
REQ-015 SHALL round by adding 2^(FRAC_BITS-1) to the full-precision sum and then arithmetic-shifting right by FRAC_BITS.
REQ-016 SHALL clip negative results to 0 and results > 2^PIXEL_WIDTH-1 to 2^PIXEL_WIDTH-1.
REQ-017 SHALL use three pipeline stages: S1 products, S2 sum+round, S3 offset+clip into the output register; latency is exactly 3 cycles from accepted input to out_valid when no stall occurs.
REQ-018 SHALL accept input on in_valid&&in_ready; advance = !out_valid || out_ready; the whole pipe holds when !advance; in_ready = advance && !commit_pending.
REQ-019 SHALL hold out_pix and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL, on a bypass-sampled beat, output in_pix unchanged at the same 3-cycle latency; bypass is sampled per beat at S1 and travels with the data.
REQ-021 SHALL set commit_pending on coeff_commit; while pending, no new input is accepted; the active set is copied when S1..S3 hold no valid beat, and pending clears that same cycle.
REQ-022 SHALL OR a coeff_commit arriving while pending into the same pending request.
REQ-023 SHALL let a shadow write coincident with the copy cycle land in shadow only; the copy uses the pre-write shadow value.
REQ-024 SHALL use the active set for all in-flight beats; the active set never changes under a beat in flight.

Reset
REQ-025 SHALL, while reset_n=0: clear all stage valids, out_valid, commit_pending and out_pix to 0; set active and shadow M to identity (1.0 = 2^FRAC_BITS) and O to 0.
REQ-026 SHALL drop in-flight beats on reset mid-operation, with no output produced for them after reset_n rises.
REQ-027 SHALL make in_ready high in the first cycle after reset_n deasserts.

Structure
REQ-028 SHALL place coeff_t, offset_t, the accumulator width function, the ID_COEFF constant, and address decode constants in shared package cc_pkg.
REQ-029 SHALL implement S3 per channel in one sub-module cc_round_clip (signed sum in, offset in, PIXEL_WIDTH-bit saturated result out), instantiated NUM_CH times.

Verification
REQ-030 SHALL check post-reset identity: in (100,200,300) -> out (100,200,300) exactly 3 cycles later.
REQ-031 SHALL check rounding: M[0][0]=0.5 (32), others 0, in0=3 -> out0=2 (1.5 rounds up); in0=1 -> out0=1.
REQ-032 SHALL check clipping: M[0][0]=2.0 with in0=40000 -> out0=65535; M[0][0]=-1.0 with in0=5 -> out0=0; O[0]=-10 with in0=4 at identity -> out0=0.
REQ-033 SHALL check backpressure: stream 10 beats while out_ready toggles 1,0,0,1 -> all 10 outputs arrive in order, none lost or duplicated, out_pix stable during stall.
REQ-034 SHALL check commit: write new M while 3 beats are in flight, then pulse commit -> the in-flight beats use the old M, in_ready is low until drain, and the next beat uses the new M.
REQ-035 SHALL check reset mid-stream: assert reset_n=0 with 2 beats in flight -> out_valid=0, and no stray output after release.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types, sizing helpers and address-map constants for the colour matrix pipe.
// The typedefs describe the default configuration; the module derives its own widths.
package cc_pkg;

    localparam int CC_PIXEL_WIDTH = 16;
    localparam int CC_NUM_CH      = 3;
    localparam int CC_INT_BITS    = 6;
    localparam int CC_FRAC_BITS   = 6;

    typedef logic signed [CC_INT_BITS+CC_FRAC_BITS-1:0] coeff_t;
    typedef logic signed [CC_PIXEL_WIDTH:0]             offset_t;

    // 1.0 in the coefficient's fixed-point format
    localparam coeff_t ID_COEFF = coeff_t'(1 << CC_FRAC_BITS);

    typedef enum logic {
        CS_IDLE    = 1'b0,
        CS_PENDING = 1'b1
    } commit_state_t;

    // Product is (pw+1) x (ib+fb) signed, NUM_CH terms are summed, plus a rounding bit and margin.
    function automatic int acc_width(input int pw, input int nch, input int ib, input int fb);
        return pw + 1 + ib + fb + $clog2(nch) + 2;
    endfunction

    function automatic int addr_width(input int nch);
        return $clog2(nch * nch + nch);
    endfunction

    // Offsets O[r] live directly after the NUM_CH x NUM_CH matrix entries.
    function automatic int offset_base(input int nch);
        return nch * nch;
    endfunction

endpackage

// File: rtl/cc_round_clip.sv
// Output stage for one channel: adds the signed offset to the rounded sum and
// saturates the result into the unsigned pixel range.
module cc_round_clip #(
    parameter int PIXEL_WIDTH = 16,
    parameter int SUM_W       = 33,
    parameter int OFF_W       = 17
) (
    input  logic signed [SUM_W-1:0]       sum,
    input  logic signed [OFF_W-1:0]       offset,
    output logic        [PIXEL_WIDTH-1:0] result
);

    localparam logic signed [SUM_W:0] MAX_V = {{(SUM_W+1-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

    logic signed [SUM_W:0] total;

    always_comb begin
        total = (SUM_W+1)'(sum) + (SUM_W+1)'(offset);
        if (total[SUM_W]) begin
            result = '0;
        end else if (total > MAX_V) begin
            result = '1;
        end else begin
            result = total[PIXEL_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/color_matrix_pipe.sv
// 3-stage colour-space matrix (products, sum+round, offset+clip) with shadow/active
// coefficient banks; a commit copies shadow to active only once the pipe is empty.
module color_matrix_pipe
    import cc_pkg::*;
#(
    parameter int PIXEL_WIDTH = 16,
    parameter int NUM_CH      = 3,
    parameter int INT_BITS    = 6,
    parameter int FRAC_BITS   = 6
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_CH*PIXEL_WIDTH-1:0]          in_pix,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM_CH*PIXEL_WIDTH-1:0]          out_pix,
    input  logic                                   coeff_we,
    input  logic [cc_pkg::addr_width(NUM_CH)-1:0]  coeff_addr,
    input  logic signed [INT_BITS+FRAC_BITS-1:0]   coeff_wdata,
    input  logic                                   coeff_commit,
    input  logic                                   bypass,
    output logic                                   commit_pending
);

    // Handshake: a beat moves on a clock edge where valid && ready; out_pix/out_valid
    // hold while out_valid && !out_ready, and the whole pipe freezes with them.
    localparam int CW     = INT_BITS + FRAC_BITS;
    localparam int OW     = PIXEL_WIDTH + 1;
    localparam int NM     = NUM_CH * NUM_CH;
    localparam int ADDR_W = addr_width(NUM_CH);
    localparam int O_BASE = offset_base(NUM_CH);
    localparam int ACC_W  = acc_width(PIXEL_WIDTH, NUM_CH, INT_BITS, FRAC_BITS);
    localparam int EXT_W  = (CW > OW) ? CW : OW;

    localparam logic signed [CW-1:0]    ID_C    = CW'(1) << FRAC_BITS;
    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1) << (FRAC_BITS - 1);

    logic signed [CW-1:0]    m_sh  [NM];
    logic signed [CW-1:0]    m_act [NM];
    logic signed [OW-1:0]    o_sh  [NUM_CH];
    logic signed [OW-1:0]    o_act [NUM_CH];
    logic signed [EXT_W-1:0] wdata_ext;

    commit_state_t state, state_nxt;
    logic          do_copy;
    logic          pipe_empty;
    logic          advance;
    logic          in_accept;

    logic                          s1_valid, s2_valid;
    logic                          s1_bypass, s2_bypass;
    logic [NUM_CH*PIXEL_WIDTH-1:0] s1_pix, s2_pix;
    logic signed [ACC_W-1:0]       prod_c  [NM];
    logic signed [ACC_W-1:0]       s1_prod [NM];
    logic signed [ACC_W-1:0]       rnd_c   [NUM_CH];
    logic signed [ACC_W-1:0]       s2_sum  [NUM_CH];
    logic signed [ACC_W-1:0]       pix_ext, coef_ext, acc;
    logic [NUM_CH*PIXEL_WIDTH-1:0] clip_c;

    assign advance        = !out_valid || out_ready;
    assign commit_pending = (state == CS_PENDING);
    assign in_ready       = advance && !commit_pending;
    assign in_accept      = in_valid && in_ready;
    assign pipe_empty     = !s1_valid && !s2_valid && !out_valid;
    assign wdata_ext      = EXT_W'(coeff_wdata);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A commit arriving while one is already pending merges into it.
    always_comb begin
        state_nxt = state;
        do_copy   = 1'b0;
        case (state)
            CS_IDLE:    if (coeff_commit) state_nxt = CS_PENDING;
            CS_PENDING: if (pipe_empty) begin
                do_copy   = 1'b1;
                state_nxt = CS_IDLE;
            end
            default:    state_nxt = CS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NM; i++) m_sh[i] <= ((i % (NUM_CH + 1)) == 0) ? ID_C : '0;
            for (int r = 0; r < NUM_CH; r++) o_sh[r] <= '0;
        end else if (coeff_we) begin
            for (int i = 0; i < NM; i++) begin
                if (coeff_addr == ADDR_W'(i)) m_sh[i] <= coeff_wdata;
            end
            for (int r = 0; r < NUM_CH; r++) begin
                if (coeff_addr == ADDR_W'(O_BASE + r)) o_sh[r] <= wdata_ext[OW-1:0];
            end
        end
    end

    // Nonblocking copy: a shadow write in the copy cycle lands after the copy samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NM; i++) m_act[i] <= ((i % (NUM_CH + 1)) == 0) ? ID_C : '0;
            for (int r = 0; r < NUM_CH; r++) o_act[r] <= '0;
        end else if (do_copy) begin
            for (int i = 0; i < NM; i++) m_act[i] <= m_sh[i];
            for (int r = 0; r < NUM_CH; r++) o_act[r] <= o_sh[r];
        end
    end

    always_comb begin
        pix_ext  = '0;
        coef_ext = '0;
        for (int r = 0; r < NUM_CH; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pix_ext  = ACC_W'($signed({1'b0, in_pix[c*PIXEL_WIDTH +: PIXEL_WIDTH]}));
                coef_ext = ACC_W'(m_act[r*NUM_CH+c]);
                prod_c[r*NUM_CH+c] = pix_ext * coef_ext;
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int r = 0; r < NUM_CH; r++) begin
            acc = ROUND_C;
            for (int c = 0; c < NUM_CH; c++) acc = acc + s1_prod[r*NUM_CH+c];
            rnd_c[r] = acc >>> FRAC_BITS;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_s3
        cc_round_clip #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .SUM_W       (ACC_W),
            .OFF_W       (OW)
        ) u_round_clip (
            .sum    (s2_sum[g]),
            .offset (o_act[g]),
            .result (clip_c[g*PIXEL_WIDTH +: PIXEL_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_bypass <= 1'b0;
            s2_bypass <= 1'b0;
            s1_pix    <= '0;
            s2_pix    <= '0;
            out_pix   <= '0;
            for (int i = 0; i < NM; i++) s1_prod[i] <= '0;
            for (int r = 0; r < NUM_CH; r++) s2_sum[r] <= '0;
        end else if (advance) begin
            s1_valid  <= in_accept;
            s1_bypass <= bypass;
            s1_pix    <= in_pix;
            for (int i = 0; i < NM; i++) s1_prod[i] <= prod_c[i];
            s2_valid  <= s1_valid;
            s2_bypass <= s1_bypass;
            s2_pix    <= s1_pix;
            for (int r = 0; r < NUM_CH; r++) s2_sum[r] <= rnd_c[r];
            out_valid <= s2_valid;
            if (s2_valid) out_pix <= s2_bypass ? s2_pix : clip_c;
        end
    end

endmodule

// File: tb/tb_color_matrix_pipe.sv
// Directed bench for color_matrix_pipe: a fixed-point reference model feeds an
// expected queue at acceptance time; a negedge monitor pops and compares outputs.
module tb_color_matrix_pipe;

    localparam int PW = 16;
    localparam int W  = 48;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_pix = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_pix;
    logic         coeff_we = 1'b0;
    logic [3:0]   coeff_addr = '0;
    logic signed [11:0] coeff_wdata = '0;
    logic         coeff_commit = 1'b0;
    logic         bypass = 1'b0;
    logic         commit_pending;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    longint msh[9], mact[9], osh[3], oact[3];
    bit commit_req = 1'b0;

    bit bp_en = 1'b0;
    bit bp_bit = 1'b1;
    bit or_force = 1'b1;
    int bp_ph = 0;

    logic [W-1:0] prev_pix = '0;
    bit stall_prev = 1'b0;

    always #5 clk = ~clk;

    assign out_ready = bp_en ? bp_bit : or_force;

    // out_ready pattern 1,0,0,1 repeating while backpressure is enabled
    always @(posedge clk) begin
        #2;
        bp_bit = ((bp_ph % 4) == 0) || ((bp_ph % 4) == 3);
        if (bp_en) bp_ph++;
    end

    color_matrix_pipe dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pix         (in_pix),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pix        (out_pix),
        .coeff_we       (coeff_we),
        .coeff_addr     (coeff_addr),
        .coeff_wdata    (coeff_wdata),
        .coeff_commit   (coeff_commit),
        .bypass         (bypass),
        .commit_pending (commit_pending)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] px(input int a, input int b, input int c);
        logic [15:0] va, vb, vc;
        va = a[15:0];
        vb = b[15:0];
        vc = c[15:0];
        return {vc, vb, va};
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] pix, input bit byp);
        logic [W-1:0] res;
        longint acc;
        res = '0;
        if (byp) return pix;
        for (int r = 0; r < 3; r++) begin
            acc = 0;
            for (int c = 0; c < 3; c++) acc += longint'(pix[c*PW +: PW]) * mact[r*3+c];
            acc = (acc + 32) >>> 6;
            acc = acc + oact[r];
            if (acc < 0) acc = 0;
            if (acc > 65535) acc = 65535;
            res[r*PW +: PW] = acc[15:0];
        end
        return res;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) begin
            msh[i]  = ((i % 4) == 0) ? 64 : 0;
            mact[i] = msh[i];
        end
        for (int r = 0; r < 3; r++) begin
            osh[r]  = 0;
            oact[r] = 0;
        end
        commit_req = 1'b0;
    endfunction

    function automatic void apply_commit();
        for (int i = 0; i < 9; i++) mact[i] = msh[i];
        for (int r = 0; r < 3; r++) oact[r] = osh[r];
        commit_req = 1'b0;
    endfunction

    // Called at posedge+1; returns at posedge+1.
    task automatic wr(input int addr, input int val);
        coeff_we    = 1'b1;
        coeff_addr  = addr[3:0];
        coeff_wdata = val[11:0];
        @(posedge clk); #1;
        coeff_we = 1'b0;
        if (addr < 9) msh[addr] = val;
        else if (addr < 12) osh[addr-9] = val;
    endtask

    task automatic commit();
        coeff_commit = 1'b1;
        @(posedge clk); #1;
        coeff_commit = 1'b0;
        commit_req = 1'b1;
    endtask

    task automatic wait_commit();
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (commit_pending && i < 100);
        check("commit_cleared", {63'd0, commit_pending}, 64'd0);
        apply_commit();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [W-1:0] pix, input bit byp);
        bit acc;
        int i;
        acc = 1'b0;
        i = 0;
        in_valid = 1'b1;
        in_pix   = pix;
        bypass   = byp;
        while (!acc && i < 200) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                if (commit_req) apply_commit();
                exp_q.push_back(model(pix, byp));
            end
            @(posedge clk); #1;
            i++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_timeout: observed in_ready low for %0d cycles expected acceptance", i);
        end
        in_valid = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_pix", 64'(out_pix), 64'(prev_pix));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL stray_output: observed %0h expected no output", out_pix);
                end else begin
                    check("out_pix", 64'(out_pix), 64'(exp_q.pop_front()));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_pix   = out_pix;
        end
    end

    initial begin
        #200000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pix", 64'(out_pix), 64'd0);
        check("rst_pending", {63'd0, commit_pending}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // identity and 3-cycle latency
        send(px(100, 200, 300), 1'b0);
        @(negedge clk);
        check("lat_c1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("lat_c2", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("lat_c3", {63'd0, out_valid}, 64'd1);
        check("identity_pix", 64'(out_pix), 64'(px(100, 200, 300)));
        @(posedge clk); #1;
        drain();

        // rounding with M00 = 0.5; out-of-range addresses are ignored
        for (int i = 0; i < 9; i++) wr(i, (i == 0) ? 32 : 0);
        wr(12, 77);
        wr(15, -5);
        commit();
        wait_commit();
        send(px(3, 7, 9), 1'b0);
        send(px(1, 0, 0), 1'b0);
        send(px(2, 5, 5), 1'b0);
        drain();

        // clipping high, clipping low, offset clipping
        wr(0, 128);
        commit();
        wait_commit();
        send(px(40000, 1, 2), 1'b0);
        wr(0, -64);
        commit();
        wait_commit();
        send(px(5, 0, 0), 1'b0);
        wr(0, 64);
        wr(4, 64);
        wr(8, 64);
        wr(9, -10);
        wr(10, 10);
        commit();
        wait_commit();
        send(px(4, 65530, 100), 1'b0);
        send(px(4, 65530, 100), 1'b1);
        send(px(1000, 2000, 3000), 1'b0);
        drain();

        // mixed matrix with random pixels
        wr(1, 16);
        wr(3, -32);
        wr(5, 100);
        wr(6, 7);
        commit();
        wait_commit();
        for (int i = 0; i < 4; i++) begin
            send(px($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535)),
                 bit'(i == 2));
        end
        drain();

        // backpressure: 10 beats with out_ready toggling
        bp_ph = 0;
        bp_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(px($urandom_range(0, 65535), $urandom_range(0, 4095), $urandom_range(0, 255)), 1'b0);
        end
        drain();
        bp_en = 1'b0;

        // commit with 3 beats held in flight
        or_force = 1'b0;
        send(px(10, 20, 30), 1'b0);
        send(px(40, 50, 60), 1'b0);
        send(px(70, 80, 90), 1'b0);
        wr(0, 128);
        wr(9, 0);
        commit();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pending_ready_low", {63'd0, in_ready}, 64'd0);
            check("pending_flag", {63'd0, commit_pending}, 64'd1);
        end
        @(posedge clk); #1;
        or_force = 1'b1;
        send(px(11, 22, 33), 1'b0);
        @(negedge clk);
        check("pending_done", {63'd0, commit_pending}, 64'd0);
        @(posedge clk); #1;
        drain();

        // reset with 2 beats in flight
        send(px(500, 600, 700), 1'b0);
        send(px(800, 900, 1000), 1'b0);
        reset_n = 1'b0;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_pending", {63'd0, commit_pending}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_midrst", {63'd0, in_ready}, 64'd1);
        repeat (6) @(negedge clk);
        check("no_stray_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        send(px(100, 200, 300), 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
